// File: rtl/dtlb_refill_seq_pkg.sv
// Shared types and constants for the DTLB refill sequencer.
// Holds the FSM state encoding, the sweep geometry and the completion status record.
package dtlb_refill_seq_pkg;

  localparam int SETS  = 16;
  localparam int WAYS  = 8;
  localparam int BEATS = 3;
  localparam int CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WREQ   = 3'd1,
    S_WWAIT  = 3'd2,
    S_COMMIT = 3'd3,
    S_INVL1  = 3'd4,
    S_FLUSH  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  typedef struct packed {
    logic valid;
    logic fault;
  } done_status_t;

endpackage

// File: rtl/dtlb_refill_beatbuf.sv
// Three-slot capture of page-walk data beats with a slot counter and sticky fault.
// o_full is combinational: high on the load that fills the last slot.
module dtlb_refill_beatbuf
  import dtlb_refill_seq_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_fault,
  output logic [DATA_W-1:0] o_beat0,
  output logic [DATA_W-1:0] o_beat1,
  output logic [DATA_W-1:0] o_beat2,
  output logic              o_fault,
  output logic              o_full
);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_beat [BEATS];
  logic              r_fault;

  assign o_full  = i_load && (r_cnt == CNT_W'(BEATS - 1));
  assign o_fault = r_fault;
  assign o_beat0 = r_beat[0];
  assign o_beat1 = r_beat[1];
  assign o_beat2 = r_beat[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
      for (int i = 0; i < BEATS; i++) r_beat[i] <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else if (i_load) begin
      for (int i = 0; i < BEATS; i++) begin
        if (r_cnt == CNT_W'(i)) r_beat[i] <= i_data;
      end
      r_fault <= r_fault | i_fault;
      r_cnt   <= o_full ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dtlb_refill_seq.sv
// Write-side sequencer for the data TLB: miss refill via page walk, single-entry
// invalidate, and a full flush that sweeps every set/way with forced-way writes.
module dtlb_refill_seq #(
  parameter int VA_W   = 51,
  parameter int DATA_W = 64,
  parameter int SETS   = 16,
  parameter int WAYS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  output logic              miss_ready,
  input  logic [VA_W-1:0]   miss_addr,
  input  logic              invl_valid,
  output logic              invl_ready,
  input  logic              invl_all,
  input  logic [VA_W-1:0]   invl_addr,
  output logic              walk_req_valid,
  input  logic              walk_req_ready,
  output logic [VA_W-1:0]   walk_req_addr,
  input  logic              walk_rsp_valid,
  input  logic [DATA_W-1:0] walk_rsp_data,
  input  logic              walk_rsp_fault,
  output logic [VA_W-1:0]   write_addr,
  output logic [DATA_W-1:0] write_data0,
  output logic [DATA_W-1:0] write_data1,
  output logic [DATA_W-1:0] write_data2,
  output logic              write_wen,
  output logic              write_xstant,
  output logic              write_invl,
  output logic              force_way_en,
  output logic [2:0]        force_way,
  output logic              done_valid,
  output logic              done_fault,
  output logic              busy,
  output logic [2:0]        dbg_state
);
  import dtlb_refill_seq_pkg::*;

  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // initiator holds valid and its payload stable until that edge.

  state_t            r_state, w_state_nxt;
  logic [VA_W-1:0]   r_addr;
  logic [SET_W-1:0]  r_set;
  logic [WAY_W-1:0]  r_way;
  logic [DATA_W-1:0] r_hold0, r_hold1, r_hold2;
  logic [DATA_W-1:0] w_beat0, w_beat1, w_beat2;
  logic              w_fault, w_full, w_clear, w_load, w_flush_last;
  done_status_t      w_done;

  assign w_load       = (r_state == S_WWAIT) && walk_rsp_valid;
  assign w_clear      = ((r_state == S_IDLE) && invl_valid) ||
                        ((r_state == S_WREQ) && walk_req_ready);
  assign w_flush_last = (r_set == SET_W'(SETS - 1)) && (r_way == WAY_W'(WAYS - 1));

  dtlb_refill_beatbuf #(.DATA_W(DATA_W)) u_beatbuf (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (w_clear),
    .i_load  (w_load),
    .i_data  (walk_rsp_data),
    .i_fault (walk_rsp_fault),
    .o_beat0 (w_beat0),
    .o_beat1 (w_beat1),
    .o_beat2 (w_beat2),
    .o_fault (w_fault),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_set   <= '0;
      r_way   <= '0;
      r_hold0 <= '0;
      r_hold1 <= '0;
      r_hold2 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (invl_valid && !invl_all) r_addr <= invl_addr;
        else if (!invl_valid && miss_valid) r_addr <= miss_addr;
        if (invl_valid && invl_all) begin
          r_set <= '0;
          r_way <= '0;
        end
      end
      if (r_state == S_FLUSH) begin
        if (r_way == WAY_W'(WAYS - 1)) begin
          r_way <= '0;
          r_set <= r_set + 1'b1;
        end else begin
          r_way <= r_way + 1'b1;
        end
      end
      // Write data only moves on a successful fill so the TLB port sees stable words.
      if ((r_state == S_COMMIT) && !w_fault) begin
        r_hold0 <= w_beat0;
        r_hold1 <= w_beat1;
        r_hold2 <= w_beat2;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    miss_ready     = 1'b0;
    invl_ready     = 1'b0;
    walk_req_valid = 1'b0;
    write_addr     = '0;
    write_data0    = r_hold0;
    write_data1    = r_hold1;
    write_data2    = r_hold2;
    write_wen      = 1'b0;
    write_xstant   = 1'b0;
    write_invl     = 1'b0;
    force_way_en   = 1'b0;
    force_way      = 3'd0;
    w_done         = '0;
    case (r_state)
      S_IDLE: begin
        invl_ready = 1'b1;
        miss_ready = !invl_valid;
        if (invl_valid) w_state_nxt = invl_all ? S_FLUSH : S_INVL1;
        else if (miss_valid) w_state_nxt = S_WREQ;
      end
      S_WREQ: begin
        walk_req_valid = 1'b1;
        if (walk_req_ready) w_state_nxt = S_WWAIT;
      end
      S_WWAIT: begin
        if (w_full) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        write_data0 = w_beat0;
        write_data1 = w_beat1;
        write_data2 = w_beat2;
        if (!w_fault) begin
          write_wen  = 1'b1;
          write_addr = r_addr;
        end
        w_state_nxt = S_DONE;
      end
      S_INVL1: begin
        write_wen    = 1'b1;
        write_xstant = 1'b1;
        write_invl   = 1'b1;
        write_addr   = r_addr;
        w_state_nxt  = S_DONE;
      end
      S_FLUSH: begin
        write_wen    = 1'b1;
        write_xstant = 1'b1;
        write_invl   = 1'b1;
        force_way_en = 1'b1;
        force_way    = 3'(r_way);
        write_addr   = VA_W'(r_set);
        if (w_flush_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done.valid = 1'b1;
        w_done.fault = w_fault;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign walk_req_addr = r_addr;
  assign done_valid    = w_done.valid;
  assign done_fault    = w_done.fault;
  assign busy          = (r_state != S_IDLE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_dtlb_refill_seq.sv
// Bench for dtlb_refill_seq: table of refill/invalidate records plus hand-written
// flush, priority and mid-walk reset sequences, checked through a write/done scoreboard.
module tb_dtlb_refill_seq;

  localparam int VA_W   = 51;
  localparam int DATA_W = 64;

  logic              clk, rst;
  logic              miss_valid, miss_ready;
  logic [VA_W-1:0]   miss_addr;
  logic              invl_valid, invl_ready, invl_all;
  logic [VA_W-1:0]   invl_addr;
  logic              walk_req_valid, walk_req_ready;
  logic [VA_W-1:0]   walk_req_addr;
  logic              walk_rsp_valid, walk_rsp_fault;
  logic [DATA_W-1:0] walk_rsp_data;
  logic [VA_W-1:0]   write_addr;
  logic [DATA_W-1:0] write_data0, write_data1, write_data2;
  logic              write_wen, write_xstant, write_invl, force_way_en;
  logic [2:0]        force_way;
  logic              done_valid, done_fault, busy;
  logic [2:0]        dbg_state;

  dtlb_refill_seq #(.VA_W(VA_W), .DATA_W(DATA_W), .SETS(16), .WAYS(8)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .invl_valid(invl_valid), .invl_ready(invl_ready), .invl_all(invl_all),
    .invl_addr(invl_addr),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
    .walk_req_addr(walk_req_addr),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data(walk_rsp_data),
    .walk_rsp_fault(walk_rsp_fault),
    .write_addr(write_addr), .write_data0(write_data0), .write_data1(write_data1),
    .write_data2(write_data2), .write_wen(write_wen), .write_xstant(write_xstant),
    .write_invl(write_invl), .force_way_en(force_way_en), .force_way(force_way),
    .done_valid(done_valid), .done_fault(done_fault), .busy(busy),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic              chk_data;
    logic [VA_W-1:0]   addr;
    logic [DATA_W-1:0] d0, d1, d2;
    logic              xstant, invl, fen;
    logic [2:0]        way;
  } wr_t;

  typedef struct {
    logic              is_invl;
    logic [VA_W-1:0]   addr;
    logic [DATA_W-1:0] b0, b1, b2;
    int                fault_beat;
    int                req_delay;
    logic              exp_write;
    logic              exp_fault;
  } vec_t;

  wr_t        exp_q[$];
  logic [0:0] done_q[$];
  wr_t        mon_e;
  logic [0:0] mon_f;
  vec_t       vecs[8];
  logic [DATA_W-1:0] last_d0, last_d1, last_d2;
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst && write_wen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'b0, write_wen}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", write_addr, mon_e.addr);
        chk("wr_xstant", write_xstant, mon_e.xstant);
        chk("wr_invl", write_invl, mon_e.invl);
        chk("wr_force_en", force_way_en, mon_e.fen);
        chk("wr_force_way", force_way, mon_e.way);
        if (mon_e.chk_data) begin
          chk("wr_data0", write_data0, mon_e.d0);
          chk("wr_data1", write_data1, mon_e.d1);
          chk("wr_data2", write_data2, mon_e.d2);
        end
      end
    end
    if (rst && done_valid) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", {63'b0, done_valid}, 64'd0);
      end else begin
        mon_f = done_q.pop_front();
        chk("done_fault", done_fault, mon_f);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_invl_ready", invl_ready, 1);
    chk("rst_walk_req_valid", walk_req_valid, 0);
    chk("rst_walk_req_addr", walk_req_addr, 0);
    chk("rst_write_wen", write_wen, 0);
    chk("rst_write_xstant", write_xstant, 0);
    chk("rst_write_invl", write_invl, 0);
    chk("rst_write_addr", write_addr, 0);
    chk("rst_write_data0", write_data0, 0);
    chk("rst_write_data2", write_data2, 0);
    chk("rst_force", {force_way_en, force_way}, 0);
    chk("rst_done", {done_valid, done_fault}, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic drive_beats(input logic [DATA_W-1:0] b0, b1, b2, input int fault_beat,
                             input int n_beats);
    logic [DATA_W-1:0] b[3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    for (int i = 0; i < n_beats; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      walk_rsp_valid = 1'b1;
      walk_rsp_data  = b[i];
      walk_rsp_fault = (i == fault_beat);
      @(negedge clk);
      walk_rsp_valid = 1'b0;
      walk_rsp_fault = 1'b0;
    end
  endtask

  // Accepts a miss, completes the walk handshake and leaves the walk in WWAIT.
  task automatic start_miss(input logic [VA_W-1:0] addr, input int req_delay);
    int n = 0;
    miss_valid = 1'b1;
    miss_addr  = addr;
    #1;
    while (!miss_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!miss_ready) chk("miss_ready_timeout", miss_ready, 1);
    @(negedge clk);
    miss_valid = 1'b0;
    chk("walk_req_cycle1", walk_req_valid, 1);
    chk("walk_req_addr", walk_req_addr, addr);
    repeat (req_delay) begin
      @(negedge clk);
      chk("walk_req_hold", walk_req_valid, 1);
    end
    walk_req_ready = 1'b1;
    @(negedge clk);
    walk_req_ready = 1'b0;
    chk("walk_req_drop", walk_req_valid, 0);
  endtask

  task automatic do_miss(input vec_t v);
    wr_t e;
    start_miss(v.addr, v.req_delay);
    if (v.exp_write) begin
      e = '{chk_data: 1'b1, addr: v.addr, d0: v.b0, d1: v.b1, d2: v.b2,
            xstant: 1'b0, invl: 1'b0, fen: 1'b0, way: 3'd0};
      exp_q.push_back(e);
      last_d0 = v.b0; last_d1 = v.b1; last_d2 = v.b2;
    end
    done_q.push_back(v.exp_fault);
    drive_beats(v.b0, v.b1, v.b2, v.fault_beat, 3);
    chk("commit_wen", write_wen, v.exp_write);
    @(negedge clk);
    chk("done_latency", done_valid, 1);
    chk("hold_data0", write_data0, last_d0);
    chk("hold_data1", write_data1, last_d1);
    chk("hold_data2", write_data2, last_d2);
  endtask

  task automatic push_invl(input logic [VA_W-1:0] addr);
    wr_t e;
    e = '{chk_data: 1'b0, addr: addr, d0: '0, d1: '0, d2: '0,
          xstant: 1'b1, invl: 1'b1, fen: 1'b0, way: 3'd0};
    exp_q.push_back(e);
    done_q.push_back(1'b0);
  endtask

  task automatic do_invl(input logic [VA_W-1:0] addr);
    int n = 0;
    invl_valid = 1'b1;
    invl_all   = 1'b0;
    invl_addr  = addr;
    #1;
    while (!invl_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!invl_ready) chk("invl_ready_timeout", invl_ready, 1);
    push_invl(addr);
    @(negedge clk);
    invl_valid = 1'b0;
    chk("invl_wen_cycle1", write_wen, 1);
    @(negedge clk);
    chk("invl_done_cycle2", done_valid, 1);
  endtask

  task automatic do_flush();
    wr_t e;
    wait_idle();
    invl_valid = 1'b1;
    invl_all   = 1'b1;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 8; w++) begin
        e = '{chk_data: 1'b0, addr: VA_W'(s), d0: '0, d1: '0, d2: '0,
              xstant: 1'b1, invl: 1'b1, fen: 1'b1, way: 3'(w)};
        exp_q.push_back(e);
      end
    end
    done_q.push_back(1'b0);
    @(negedge clk);
    invl_valid = 1'b0;
    invl_all   = 1'b0;
    for (int k = 0; k < 128; k++) begin
      chk("flush_wen", write_wen, 1);
      chk("flush_no_done", done_valid, 0);
      @(negedge clk);
    end
    chk("flush_done_129", done_valid, 1);
    chk("flush_wen_end", write_wen, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    miss_valid = 1'b0; miss_addr = '0;
    invl_valid = 1'b0; invl_all = 1'b0; invl_addr = '0;
    walk_req_ready = 1'b0;
    walk_rsp_valid = 1'b0; walk_rsp_data = '0; walk_rsp_fault = 1'b0;
    last_d0 = '0; last_d1 = '0; last_d2 = '0;

    vecs[0] = '{1'b0, 51'h1234, 64'hA, 64'hB, 64'hC, -1, 2, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 51'h1234, 64'h1, 64'h2, 64'h3, 1, 0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 51'h55, 64'h0, 64'h0, 64'h0, -1, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 51'h7_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                64'h5555_5555_5555_5555, -1, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 51'h0, 64'h11, 64'h22, 64'h33, 2, 0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 51'h2_AAAA_AAAA_AAAA, 64'h44, 64'h55, 64'h66, 0, 3, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 51'h7_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0, -1, 0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 51'hABC, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF,
                64'h8000_0000_0000_0000, -1, 0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_invl) do_invl(vecs[i].addr);
      else do_miss(vecs[i]);
    end

    do_flush();

    // Invalidate wins over a simultaneous miss; the miss waits until after DONE.
    wait_idle();
    invl_valid = 1'b1; invl_all = 1'b0; invl_addr = 51'h77;
    miss_valid = 1'b1; miss_addr = 51'h999;
    #1;
    chk("prio_miss_ready", miss_ready, 0);
    chk("prio_invl_ready", invl_ready, 1);
    push_invl(51'h77);
    @(negedge clk);
    invl_valid = 1'b0;
    chk("prio_miss_ready_c1", miss_ready, 0);
    @(negedge clk);
    chk("prio_miss_ready_c2", miss_ready, 0);
    chk("prio_done_c2", done_valid, 1);
    @(negedge clk);
    chk("prio_miss_ready_c3", miss_ready, 1);
    do_miss('{1'b0, 51'h999, 64'h9A, 64'h9B, 64'h9C, -1, 0, 1'b1, 1'b0});

    // Reset in the middle of a walk abandons it.
    wait_idle();
    start_miss(51'h4321, 0);
    drive_beats(64'hF1, 64'hF2, 64'h0, -1, 2);
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    last_d0 = '0; last_d1 = '0; last_d2 = '0;
    @(negedge clk);
    rst = 1'b1;
    walk_rsp_valid = 1'b1; walk_rsp_data = 64'hBAD; walk_rsp_fault = 1'b0;
    @(negedge clk);
    walk_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", busy, 0);
    do_miss('{1'b0, 51'h4321, 64'hC1, 64'hC2, 64'hC3, -1, 1, 1'b1, 1'b0});

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
